// File: rtl/non_max_suppression_if.sv
// ---------------------------------------------------------------------------
// non_max_suppression_if
// Stream bundle between gradient_calculation, the NMS stage and the
// downstream hysteresis/threshold stage.
//   nms_mag_in / nms_dir_in / nms_data_in_valid    : input pixel stream
//   nms_magnitude_out / nms_direction_out          : thinned-edge result
//   nms_out_valid                                  : one-cycle result strobe
//   nms_pixel_out                                  : 8-bit saturated result,
//                                                    only with NMS_SAT8_OUT_EN
// Modports: master = stream producer/consumer side (bench or neighbours),
//           slave  = the NMS block itself.
// ---------------------------------------------------------------------------
interface non_max_suppression_if #(
  parameter int MAG_W = 11
);
  logic [MAG_W-1:0] nms_mag_in;
  logic [1:0]       nms_dir_in;
  logic             nms_data_in_valid;
  logic [MAG_W-1:0] nms_magnitude_out;
  logic [1:0]       nms_direction_out;
  logic             nms_out_valid;
`ifdef NMS_SAT8_OUT_EN
  logic [7:0]       nms_pixel_out;
`endif

  modport master (
    output nms_mag_in, nms_dir_in, nms_data_in_valid,
    input  nms_magnitude_out, nms_direction_out, nms_out_valid
`ifdef NMS_SAT8_OUT_EN
    , input nms_pixel_out
`endif
  );

  modport slave (
    input  nms_mag_in, nms_dir_in, nms_data_in_valid,
    output nms_magnitude_out, nms_direction_out, nms_out_valid
`ifdef NMS_SAT8_OUT_EN
    , output nms_pixel_out
`endif
  );
endinterface

// File: rtl/non_max_suppression.sv
// ---------------------------------------------------------------------------
// non_max_suppression
// Canny non-maximum suppression on a raster stream of gradient magnitude and
// direction. Two line buffers plus a 3x3 register window give the centre
// pixel and its neighbours; the centre is zeroed unless it is >= both
// neighbours along its gradient direction.
// Ports:
//   clk   : single clock, rising edge
//   rstN  : asynchronous active-low reset
//   nms   : non_max_suppression_if.slave stream bundle
// Latency: input accepted at edge k produces nms_out_valid after edge k+2.
// Optional feature macro: NMS_SAT8_OUT_EN adds nms_pixel_out (8-bit
// saturated copy of nms_magnitude_out).
// ---------------------------------------------------------------------------
module non_max_suppression #(
  parameter int IMG_WIDTH  = 508,
  parameter int IMG_HEIGHT = 508,
  parameter int MAG_W      = 11
) (
  input logic                  clk,
  input logic                  rstN,
  non_max_suppression_if.slave nms
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  function automatic logic [MAG_W-1:0] nms_keep(input logic [MAG_W-1:0] c,
                                                input logic [MAG_W-1:0] a,
                                                input logic [MAG_W-1:0] b);
    return (c >= a && c >= b) ? c : '0;
  endfunction

`ifdef NMS_SAT8_OUT_EN
  function automatic logic [7:0] sat8(input logic [MAG_W-1:0] v);
    return (v > MAG_W'(255)) ? 8'hFF : v[7:0];
  endfunction
`endif

  // Line buffers: lb1 holds row-1 (magnitude + direction), lb2 holds row-2
  // (magnitude only; only the middle row's direction is ever needed).
  logic [MAG_W+1:0] lb1_mem [IMG_WIDTH];
  logic [MAG_W-1:0] lb2_mem [IMG_WIDTH];
  logic [MAG_W+1:0] lb1_rd;
  logic [MAG_W-1:0] lb2_rd;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             in_fire;

  // win[r][c]: r=0 top (row-2), 2 bottom (current row); c=0 oldest column.
  logic [MAG_W-1:0] win_q [3][3];
  logic [MAG_W-1:0] win_d [3][3];
  logic [1:0]       dir_new_q, dir_new_d, dir_ctr_q, dir_ctr_d;
  logic             vld_p0_q, vld_p0_d;

  logic [MAG_W-1:0] res_mag_q, res_mag_d;
  logic [1:0]       res_dir_q, res_dir_d;
  logic             vld_p1_q, vld_p1_d;

  logic [MAG_W-1:0] out_mag_q, out_mag_d;
  logic [1:0]       out_dir_q, out_dir_d;
  logic             out_vld_q, out_vld_d;
`ifdef NMS_SAT8_OUT_EN
  logic [7:0]       out_pix_q, out_pix_d;
`endif

  assign in_fire = nms.nms_data_in_valid;
  assign lb1_rd  = lb1_mem[col_q];
  assign lb2_rd  = lb2_mem[col_q];

  // ---- stage p0: counters, line buffers, window shift ----
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    dir_new_d = dir_new_q;
    dir_ctr_d = dir_ctr_q;
    vld_p0_d  = in_fire && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    if (in_fire) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd[MAG_W-1:0];
      win_d[2][2] = nms.nms_mag_in;
      dir_ctr_d   = dir_new_q;
      dir_new_d   = lb1_rd[MAG_W+1:MAG_W];
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb1_mem[col_q] <= {nms.nms_dir_in, nms.nms_mag_in};
      lb2_mem[col_q] <= lb1_rd[MAG_W-1:0];
    end
  end

  // ---- stage p1: neighbour select and keep/zero decision ----
  always_comb begin
    res_dir_d = dir_ctr_q;
    unique case (dir_ctr_q)
      2'd0:    res_mag_d = nms_keep(win_q[1][1], win_q[1][0], win_q[1][2]);
      2'd1:    res_mag_d = nms_keep(win_q[1][1], win_q[0][2], win_q[2][0]);
      2'd2:    res_mag_d = nms_keep(win_q[1][1], win_q[0][1], win_q[2][1]);
      default: res_mag_d = nms_keep(win_q[1][1], win_q[0][0], win_q[2][2]);
    endcase
    vld_p1_d = vld_p0_q;
  end

  // ---- stage p2: output registers, hold value between strobes ----
  always_comb begin
    out_mag_d = out_mag_q;
    out_dir_d = out_dir_q;
    out_vld_d = vld_p1_q;
`ifdef NMS_SAT8_OUT_EN
    out_pix_d = out_pix_q;
`endif
    if (vld_p1_q) begin
      out_mag_d = res_mag_q;
      out_dir_d = res_dir_q;
`ifdef NMS_SAT8_OUT_EN
      out_pix_d = sat8(res_mag_q);
`endif
    end
  end

  // Data path registers carry no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    win_q     <= win_d;
    dir_new_q <= dir_new_d;
    dir_ctr_q <= dir_ctr_d;
    res_mag_q <= res_mag_d;
    res_dir_q <= res_dir_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col_q     <= '0;
      row_q     <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      out_mag_q <= '0;
      out_dir_q <= '0;
      out_vld_q <= 1'b0;
`ifdef NMS_SAT8_OUT_EN
      out_pix_q <= '0;
`endif
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      out_mag_q <= out_mag_d;
      out_dir_q <= out_dir_d;
      out_vld_q <= out_vld_d;
`ifdef NMS_SAT8_OUT_EN
      out_pix_q <= out_pix_d;
`endif
    end
  end

  assign nms.nms_magnitude_out = out_mag_q;
  assign nms.nms_direction_out = out_dir_q;
  assign nms.nms_out_valid     = out_vld_q;
`ifdef NMS_SAT8_OUT_EN
  assign nms.nms_pixel_out     = out_pix_q;
`endif

endmodule

// File: tb/tb_non_max_suppression.sv
// ---------------------------------------------------------------------------
// tb_non_max_suppression
// Directed bench for non_max_suppression on a 5x5 image. Each frame pattern
// has a hand-computed table of its nine expected outputs; the bench tracks
// which input completes each window and expects the matching result exactly
// two clocks later. Between strobes the outputs must hold the last result.
// ---------------------------------------------------------------------------
module tb_non_max_suppression;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int MW = 11;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  non_max_suppression_if #(.MAG_W(MW)) bus();

  non_max_suppression #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .nms  (bus)
  );

  typedef struct {
    int mag;
    int dir;
    int due;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mr       = 0;
  int mc       = 0;
  int cur_t    = 2;
  int last_mag = 0;
  int last_dir = 0;
  int last_pix = 0;

  // Expected outputs in raster order for centres (1..3, 1..3).
  int exp2[9] = '{0, 100, 0, 0, 100, 0, 0, 100, 0};
  int exp3[9] = '{0, 0, 0, 100, 100, 100, 0, 0, 0};
  int exp4[9] = '{50, 50, 50, 50, 50, 50, 50, 50, 50};
  int exp7[9] = '{700, 0, 10, 0, 200, 0, 10, 10, 10};
  int exp8[9] = '{20, 30, 40, 30, 40, 50, 40, 50, 60};
  int exp9[9] = '{60, 70, 80, 50, 60, 70, 40, 50, 60};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int mag_of(input int t, input int r, input int c);
    case (t)
      2:       return (c == 2) ? 100 : 10;
      3:       return (r == 2) ? 100 : 10;
      4:       return 50;
      7:       return (r == 1 && c == 1) ? 700 : ((r == 2 && c == 2) ? 200 : 10);
      8:       return 10 * (r + c);
      default: return 60 + 10 * (c - r);
    endcase
  endfunction

  function automatic int dir_of(input int t);
    case (t)
      2, 7:    return 0;
      3:       return 2;
      8:       return 1;
      default: return 3;
    endcase
  endfunction

  function int exp_of(input int t, input int k);
    case (t)
      2:       return exp2[k];
      3:       return exp3[k];
      4:       return exp4[k];
      7:       return exp7[k];
      8:       return exp8[k];
      default: return exp9[k];
    endcase
  endfunction

  task automatic sample();
    exp_t e;
    if (!rstN) begin
      check_eq("rst_mag", 32'(bus.nms_magnitude_out), 0);
      check_eq("rst_dir", 32'(bus.nms_direction_out), 0);
      check_eq("rst_vld", 32'(bus.nms_out_valid), 0);
`ifdef NMS_SAT8_OUT_EN
      check_eq("rst_pix", 32'(bus.nms_pixel_out), 0);
`endif
      return;
    end
    if (bus.nms_out_valid) begin
      if (q.size() == 0) begin
        check_eq("spurious_vld", 32'(bus.nms_out_valid), 0);
      end else begin
        e = q.pop_front();
        check_eq("latency", cyc, e.due);
        check_eq("mag", 32'(bus.nms_magnitude_out), e.mag);
        check_eq("dir", 32'(bus.nms_direction_out), e.dir);
        last_mag = e.mag;
        last_dir = e.dir;
        last_pix = (e.mag > 255) ? 255 : e.mag;
`ifdef NMS_SAT8_OUT_EN
        check_eq("pix", 32'(bus.nms_pixel_out), last_pix);
`endif
      end
    end else begin
      if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check_eq("missing_vld", 32'(bus.nms_out_valid), 1);
      end
      check_eq("hold_mag", 32'(bus.nms_magnitude_out), last_mag);
      check_eq("hold_dir", 32'(bus.nms_direction_out), last_dir);
`ifdef NMS_SAT8_OUT_EN
      check_eq("hold_pix", 32'(bus.nms_pixel_out), last_pix);
`endif
    end
  endtask

  task automatic step(input bit v, input int m, input int d);
    exp_t e;
    bus.nms_data_in_valid = v;
    bus.nms_mag_in        = m[MW-1:0];
    bus.nms_dir_in        = d[1:0];
    @(posedge clk);
    cyc++;
    if (v && rstN) begin
      if (mr >= 2 && mc >= 2) begin
        e.mag = exp_of(cur_t, (mr - 2) * 3 + (mc - 2));
        e.dir = dir_of(cur_t);
        e.due = cyc + 2;
        q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    #1;
    sample();
  endtask

  task automatic do_reset(input int cycles);
    rstN = 1'b0;
    #1;
    q.delete();
    mr = 0;
    mc = 0;
    last_mag = 0;
    last_dir = 0;
    last_pix = 0;
    sample();
    for (int i = 0; i < cycles; i++)
      step(1'($urandom_range(1)), int'($urandom_range(2047)), int'($urandom_range(3)));
    rstN = 1'b1;
  endtask

  task automatic drive_frame(input int t, input int gap_pct, input int n_max);
    int n = 0;
    cur_t = t;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n == n_max) return;
        while (int'($urandom_range(99)) < gap_pct)
          step(1'b0, int'($urandom_range(2047)), int'($urandom_range(3)));
        step(1'b1, mag_of(t, r, c), dir_of(t));
        n++;
      end
    end
  endtask

  initial begin
    rstN = 1'b1;
    bus.nms_data_in_valid = 1'b0;
    bus.nms_mag_in        = '0;
    bus.nms_dir_in        = '0;
    #1;
    do_reset(8);

    // Back-to-back frames, valid every cycle.
    drive_frame(2, 0, W * H);
    drive_frame(3, 0, W * H);
    drive_frame(4, 0, W * H);
    drive_frame(8, 0, W * H);
    drive_frame(9, 0, W * H);
    drive_frame(7, 0, W * H);

    // Input gaps (~40% idle) must not change values or latency.
    drive_frame(2, 40, W * H);

    // Reset mid-frame after 13 inputs, then a clean frame.
    drive_frame(3, 0, 13);
    do_reset(2);
    drive_frame(2, 0, W * H);

    for (int i = 0; i < 6; i++)
      step(1'b0, int'($urandom_range(2047)), int'($urandom_range(3)));
    check_eq("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
